// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic {RUN, MWAIT} mem_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_t;

    // RISC-V x0 is hardwired to zero; ARM r0 is an ordinary register.
    function automatic logic isZeroReg(input logic arm, input logic [REG_W-1:0] r);
        return !arm && (r == '0);
    endfunction

    function automatic fwd_t selectForward(
        input logic             arm,
        input logic [REG_W-1:0] src,
        input logic             regWriteM,
        input logic [REG_W-1:0] rdM,
        input logic             regWriteW,
        input logic [REG_W-1:0] rdW
    );
        if (regWriteM && (rdM == src) && !isZeroReg(arm, src))
            return FWD_M;
        else if (regWriteW && (rdW == src) && !isZeroReg(arm, src))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_q <= '0;
        else if (i_inc && (r_q != '1))
            r_q <= r_q + W'(1);
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the dual-ISA 5-stage core: stalls, flushes,
// E-stage forwarding, ARM PC-write tracking and data-memory wait sequencing.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_arm,
    input  logic [4:0]       i_Rs1D,
    input  logic [4:0]       i_Rs2D,
    input  logic [4:0]       i_Rs1E,
    input  logic [4:0]       i_Rs2E,
    input  logic [4:0]       i_RdE,
    input  logic [4:0]       i_RdM,
    input  logic [4:0]       i_RdW,
    input  logic             i_RegWriteM,
    input  logic             i_RegWriteW,
    input  logic             i_ResultSrcE0,
    input  logic             i_PCSrcD,
    input  logic             i_BranchTakenE,
    input  logic             i_MemReqM,
    input  logic             i_MemReadyM,
    output logic             o_StallF,
    output logic             o_StallD,
    output logic             o_StallE,
    output logic             o_StallM,
    output logic             o_StallW,
    output logic             o_FlushD,
    output logic             o_FlushE,
    output logic [1:0]       o_ForwardAE,
    output logic [1:0]       o_ForwardBE,
    output logic             o_MemErr,
    output logic [CNT_W-1:0] o_StallCnt,
    output logic [CNT_W-1:0] o_FlushCnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    mem_state_t        r_state;
    mem_state_t        w_stateNext;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [WAIT_W-1:0] w_waitNext;
    logic              w_waiting;
    logic              r_memErr;
    logic              r_armPrev;
    logic              r_pcE;
    logic              r_pcM;
    logic              r_pcW;

    logic w_memStall;
    logic w_ldStall;
    logic w_pend;
    fwd_t w_fwdA;
    fwd_t w_fwdB;

    always_comb begin
        w_fwdA     = selectForward(i_arm, i_Rs1E, i_RegWriteM, i_RdM, i_RegWriteW, i_RdW);
        w_fwdB     = selectForward(i_arm, i_Rs2E, i_RegWriteM, i_RdM, i_RegWriteW, i_RdW);
        w_memStall = i_MemReqM && !i_MemReadyM;
        w_ldStall  = i_ResultSrcE0 && ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D))
                     && !isZeroReg(i_arm, i_RdE);
        w_pend     = (i_PCSrcD && i_arm) || r_pcE || r_pcM;
    end

    // A pending memory access freezes the whole pipe and suppresses every bubble.
    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_StallM = 1'b0;
        o_StallW = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        if (w_memStall) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_StallM = 1'b1;
            o_StallW = 1'b1;
        end else begin
            o_StallF = w_ldStall || w_pend;
            o_StallD = w_ldStall;
            o_FlushD = w_pend || r_pcW || i_BranchTakenE;
            o_FlushE = w_ldStall || i_BranchTakenE;
        end
    end

    // The wait counter includes the cycle that enters MWAIT, so MemErr rises
    // after exactly MEM_TIMEOUT consecutive wait cycles.
    always_comb begin
        w_stateNext = r_state;
        w_waiting   = 1'b0;
        case (r_state)
            RUN: begin
                w_waiting = w_memStall;
                if (w_memStall)
                    w_stateNext = MWAIT;
            end
            MWAIT: begin
                w_waiting = !i_MemReadyM;
                if (i_MemReadyM)
                    w_stateNext = RUN;
            end
            default: w_stateNext = RUN;
        endcase
        if (!w_waiting)
            w_waitNext = '0;
        else if (r_waitCnt == WAIT_LIMIT)
            w_waitNext = r_waitCnt;
        else
            w_waitNext = r_waitCnt + WAIT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= RUN;
            r_waitCnt <= '0;
            r_memErr  <= 1'b0;
            r_armPrev <= 1'b0;
            r_pcE     <= 1'b0;
            r_pcM     <= 1'b0;
            r_pcW     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitNext;
            r_memErr  <= r_memErr || (w_waitNext == WAIT_LIMIT);
            r_armPrev <= i_arm;
            if (i_arm != r_armPrev) begin
                r_pcE <= 1'b0;
                r_pcM <= 1'b0;
                r_pcW <= 1'b0;
            end else if (!w_memStall) begin
                r_pcE <= i_PCSrcD && i_arm && !o_FlushE;
                r_pcM <= r_pcE;
                r_pcW <= r_pcM;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (o_StallD),
        .o_q   (o_StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (o_FlushD || o_FlushE),
        .o_q   (o_FlushCnt)
    );

    assign o_ForwardAE = w_fwdA;
    assign o_ForwardBE = w_fwdB;
    assign o_MemErr    = r_memErr;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, multi-cycle sequences and a
// randomized run against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int CNT_W       = 8;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0;
    logic [4:0] rdE = '0, rdM = '0, rdW = '0;
    logic       regWriteM = 1'b0, regWriteW = 1'b0, resultSrcE0 = 1'b0;
    logic       pcSrcD = 1'b0, branchTakenE = 1'b0, memReqM = 1'b0, memReadyM = 1'b0;

    logic             stallF, stallD, stallE, stallM, stallW, flushD, flushE, memErr;
    logic [1:0]       forwardAE, forwardBE;
    logic [CNT_W-1:0] stallCnt, flushCnt;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_arm(arm),
        .i_Rs1D(rs1D), .i_Rs2D(rs2D), .i_Rs1E(rs1E), .i_Rs2E(rs2E),
        .i_RdE(rdE), .i_RdM(rdM), .i_RdW(rdW),
        .i_RegWriteM(regWriteM), .i_RegWriteW(regWriteW), .i_ResultSrcE0(resultSrcE0),
        .i_PCSrcD(pcSrcD), .i_BranchTakenE(branchTakenE),
        .i_MemReqM(memReqM), .i_MemReadyM(memReadyM),
        .o_StallF(stallF), .o_StallD(stallD), .o_StallE(stallE), .o_StallM(stallM),
        .o_StallW(stallW), .o_FlushD(flushD), .o_FlushE(flushE),
        .o_ForwardAE(forwardAE), .o_ForwardBE(forwardBE),
        .o_MemErr(memErr), .o_StallCnt(stallCnt), .o_FlushCnt(flushCnt)
    );

    typedef struct {
        logic       arm;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       regWriteM, regWriteW, resultSrcE0, pcSrcD, branchTakenE, memReqM, memReadyM;
        logic [4:0] expStall;
        logic [1:0] expFlush;
        logic [1:0] expFwdA, expFwdB;
    } vec_t;

    vec_t tbl[12];
    int   checks = 0;
    int   failures = 0;

    // Reference model state: PC writes travel through a 3-deep queue (E, M, W).
    bit   pcq[$];
    bit   mArmPrev, mInWait, mMemErr;
    int   mWaitLen, mStallCnt, mFlushCnt;
    logic [4:0] mStall;
    logic [1:0] mFlush, mFwdA, mFwdB;
    bit   mMemStall;

    function automatic bit zr(input logic a, input logic [4:0] r);
        return !a && (r == 5'd0);
    endfunction

    function automatic logic [1:0] fwdOf(input logic [4:0] src);
        if (regWriteM && rdM == src && !zr(arm, src)) return 2'b10;
        if (regWriteW && rdW == src && !zr(arm, src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic modelReset();
        pcq = '{1'b0, 1'b0, 1'b0};
        mArmPrev = 0; mInWait = 0; mMemErr = 0;
        mWaitLen = 0; mStallCnt = 0; mFlushCnt = 0;
    endtask

    task automatic modelEval();
        bit ld, pend;
        mMemStall = memReqM && !memReadyM;
        ld   = resultSrcE0 && (rdE == rs1D || rdE == rs2D) && !zr(arm, rdE);
        pend = (pcSrcD && arm) || pcq[0] || pcq[1];
        mFwdA = fwdOf(rs1E);
        mFwdB = fwdOf(rs2E);
        if (mMemStall) begin
            mStall = 5'b11111;
            mFlush = 2'b00;
        end else begin
            mStall = {ld || pend, ld, 3'b000};
            mFlush = {pend || pcq[2] || branchTakenE, ld || branchTakenE};
        end
    endtask

    task automatic modelStep();
        bit waiting;
        if (rst) begin
            modelReset();
        end else begin
            waiting = mInWait ? !memReadyM : mMemStall;
            mWaitLen = waiting ? ((mWaitLen < MEM_TIMEOUT) ? mWaitLen + 1 : mWaitLen) : 0;
            if (mWaitLen == MEM_TIMEOUT) mMemErr = 1;
            mInWait = mInWait ? !memReadyM : mMemStall;
            if (mStall[3] && mStallCnt < CNT_MAX) mStallCnt++;
            if ((|mFlush) && mFlushCnt < CNT_MAX) mFlushCnt++;
            if (arm != mArmPrev) begin
                pcq = '{1'b0, 1'b0, 1'b0};
            end else if (!mMemStall) begin
                pcq.push_front(pcSrcD && arm && !mFlush[0]);
                void'(pcq.pop_back());
            end
            mArmPrev = arm;
        end
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        arm = v.arm; rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
        rdE = v.rdE; rdM = v.rdM; rdW = v.rdW;
        regWriteM = v.regWriteM; regWriteW = v.regWriteW; resultSrcE0 = v.resultSrcE0;
        pcSrcD = v.pcSrcD; branchTakenE = v.branchTakenE;
        memReqM = v.memReqM; memReadyM = v.memReadyM;
    endtask

    task automatic settle();
        @(negedge clk);
        modelEval();
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        vec_t idle;
        idle = '{default: '0};
        rst = 1'b1;
        applyStimulus(idle);
        settle();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [4:0] stallVec();
        return {stallF, stallD, stallE, stallM, stallW};
    endfunction

    initial begin
        vec_t v;

        v = '{default: '0}; v.rdM = 5; v.regWriteM = 1; v.rdW = 5; v.regWriteW = 1; v.rs1E = 5;
        v.expFwdA = 2'b10; tbl[0] = v;
        v.rs1E = 0; v.expFwdA = 2'b00; tbl[1] = v;
        v = '{default: '0}; v.arm = 1; v.rdW = 0; v.regWriteW = 1; v.rs2E = 0; v.rs1E = 3; v.rdM = 3;
        v.expFwdB = 2'b01; tbl[2] = v;
        v = '{default: '0}; v.arm = 1; v.resultSrcE0 = 1; v.rdE = 7; v.rs2D = 7; v.rs1D = 2;
        v.expStall = 5'b11000; v.expFlush = 2'b01; tbl[3] = v;
        v = '{default: '0}; v.resultSrcE0 = 1; v.rdE = 0; tbl[4] = v;
        v = '{default: '0}; v.resultSrcE0 = 1; v.rdE = 9; v.rs1D = 9; v.branchTakenE = 1;
        v.expStall = 5'b11000; v.expFlush = 2'b11; tbl[5] = v;
        v.memReqM = 1; v.expStall = 5'b11111; v.expFlush = 2'b00; tbl[6] = v;
        v = '{default: '0}; v.memReqM = 1; v.memReadyM = 1; v.branchTakenE = 1;
        v.expFlush = 2'b11; tbl[7] = v;
        v = '{default: '0}; v.arm = 1; v.pcSrcD = 1; v.expStall = 5'b10000; v.expFlush = 2'b10; tbl[8] = v;
        v = '{default: '0}; v.pcSrcD = 1; tbl[9] = v;
        v = '{default: '0}; v.arm = 1; v.rdM = 0; v.regWriteM = 1; v.rdW = 0; v.regWriteW = 1;
        v.expFwdA = 2'b10; v.expFwdB = 2'b10; tbl[10] = v;
        v = '{default: '0}; v.rdM = 4; v.rs1E = 4; v.rdW = 6; v.regWriteW = 1; v.rs2E = 6;
        v.expFwdB = 2'b01; tbl[11] = v;

        modelReset();
        doReset();
        settle();
        checkOutput("reset_stall", stallVec(), 0);
        checkOutput("reset_flush", {flushD, flushE}, 0);
        checkOutput("reset_memerr", memErr, 0);
        checkOutput("reset_stallcnt", stallCnt, 0);
        checkOutput("reset_flushcnt", flushCnt, 0);
        tick();

        for (int i = 0; i < 12; i++) begin
            doReset();
            applyStimulus(tbl[i]);
            settle();
            checkOutput($sformatf("vec%0d_stall", i), stallVec(), tbl[i].expStall);
            checkOutput($sformatf("vec%0d_flush", i), {flushD, flushE}, tbl[i].expFlush);
            checkOutput($sformatf("vec%0d_fwdA", i), forwardAE, tbl[i].expFwdA);
            checkOutput($sformatf("vec%0d_fwdB", i), forwardBE, tbl[i].expFwdB);
            tick();
            settle();
            checkOutput($sformatf("vec%0d_stallcnt", i), stallCnt, tbl[i].expStall[3]);
            checkOutput($sformatf("vec%0d_flushcnt", i), flushCnt, |tbl[i].expFlush);
            tick();
        end

        // ARM PC write: one-cycle PCSrcD pulse.
        begin
            bit expF[5] = '{1, 1, 1, 0, 0};
            bit expD[5] = '{1, 1, 1, 1, 0};
            doReset();
            v = '{default: '0}; v.arm = 1;
            applyStimulus(v); settle(); tick();
            for (int c = 0; c < 5; c++) begin
                v.pcSrcD = (c == 0);
                applyStimulus(v);
                settle();
                checkOutput($sformatf("pcw_c%0d_stallF", c), stallF, expF[c]);
                checkOutput($sformatf("pcw_c%0d_flushD", c), flushD, expD[c]);
                tick();
            end
        end

        // Memory wait with a PC write in flight; the tracker must stay frozen.
        begin
            logic [4:0] expS[8] = '{5'b10000, 5'b11111, 5'b11111, 5'b11111,
                                    5'b10000, 5'b10000, 5'b00000, 5'b00000};
            logic [1:0] expFl[8] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
            doReset();
            v = '{default: '0}; v.arm = 1;
            applyStimulus(v); settle(); tick();
            for (int c = 0; c < 8; c++) begin
                v.pcSrcD    = (c == 0);
                v.memReqM   = (c >= 1 && c <= 4);
                v.memReadyM = (c == 4);
                applyStimulus(v);
                settle();
                checkOutput($sformatf("mw_c%0d_stall", c), stallVec(), expS[c]);
                checkOutput($sformatf("mw_c%0d_flush", c), {flushD, flushE}, expFl[c]);
                tick();
            end
        end

        // Timeout, then reset in the middle of the wait.
        doReset();
        v = '{default: '0}; v.memReqM = 1;
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(v);
            settle();
            checkOutput($sformatf("to_c%0d_memerr", c), memErr, (c >= 5));
            checkOutput($sformatf("to_c%0d_stall", c), stallVec(), 5'b11111);
            tick();
        end
        rst = 1'b1;
        settle();
        checkOutput("to_rst_stall", stallVec(), 5'b11111);
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(v);
            settle();
            checkOutput($sformatf("to_post_c%0d_memerr", c), memErr, 0);
            if (c == 1) begin
                checkOutput("to_post_stallcnt", stallCnt, 0);
                checkOutput("to_post_flushcnt", flushCnt, 0);
            end
            tick();
        end

        // Counter saturation under a permanent load-use stall.
        doReset();
        v = '{default: '0}; v.resultSrcE0 = 1; v.rdE = 9; v.rs1D = 9;
        applyStimulus(v);
        for (int c = 0; c < CNT_MAX + 10; c++) begin
            settle();
            tick();
        end
        settle();
        checkOutput("sat_stallcnt", stallCnt, CNT_MAX);
        checkOutput("sat_flushcnt", flushCnt, CNT_MAX);
        tick();

        // Randomized run against the model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(63) == 0);
            if ($urandom_range(31) == 0) arm = ~arm;
            rs1D = 5'($urandom_range(3)); rs2D = 5'($urandom_range(3));
            rs1E = 5'($urandom_range(3)); rs2E = 5'($urandom_range(3));
            rdE  = 5'($urandom_range(3)); rdM  = 5'($urandom_range(3)); rdW = 5'($urandom_range(3));
            regWriteM    = 1'($urandom_range(1));
            regWriteW    = 1'($urandom_range(1));
            resultSrcE0  = ($urandom_range(3) == 0);
            pcSrcD       = ($urandom_range(5) == 0);
            branchTakenE = ($urandom_range(5) == 0);
            memReqM      = ($urandom_range(2) == 0);
            memReadyM    = ($urandom_range(2) != 0);
            settle();
            checkOutput("rnd_stall", stallVec(), mStall);
            checkOutput("rnd_flush", {flushD, flushE}, mFlush);
            checkOutput("rnd_fwdA", forwardAE, mFwdA);
            checkOutput("rnd_fwdB", forwardBE, mFwdB);
            checkOutput("rnd_memerr", memErr, mMemErr);
            checkOutput("rnd_stallcnt", stallCnt, mStallCnt);
            checkOutput("rnd_flushcnt", flushCnt, mFlushCnt);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
